// File: rtl/mmio_display_pkg.sv
// ============================================================================
// Module      : mmio_display_pkg
// Description : Register map, CTRL bit indices and seven-segment decode
//               shared by the MMIO display/switch peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mmio_display_pkg;

    localparam logic [1:0] OFF_DISPLAY = 2'd0;
    localparam logic [1:0] OFF_CTRL    = 2'd1;
    localparam logic [1:0] OFF_SWITCH  = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    localparam int CTRL_LZB    = 0;
    localparam int CTRL_EN     = 1;
    localparam int CTRL_SWMODE = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_BLINK  = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    // Active-low {g,f,e,d,c,b,a}; letters A,b,C,d,E,F in mixed case.
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/switch_debounce.sv
// ============================================================================
// Module      : switch_debounce
// Description : Two-flop synchroniser plus stability-counter debouncer with
//               accepted-value register and one-cycle change pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce #(
    parameter int W            = 8,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] sw_async_i,
    output logic [W-1:0] stable_o,
    output logic         change_o
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [W-1:0]     sync1_q;
    logic [W-1:0]     sync2_q;
    logic [W-1:0]     cand_q;
    logic [W-1:0]     stable_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_settled;

    assign w_settled = (sync2_q == cand_q) && (cnt_q == CNT_MAX);
    assign change_o  = w_settled && (cand_q != stable_q);
    assign stable_o  = stable_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= sw_async_i;
            sync2_q <= sync1_q;
            // The cycle that loads a new candidate is its first stable cycle.
            if (sync2_q != cand_q) begin
                cand_q <= sync2_q;
                cnt_q  <= CNT_ONE;
            end else if (cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
            if (change_o) begin
                stable_q <= cand_q;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_display_ctrl.sv
// ============================================================================
// Module      : mmio_display_ctrl
// Description : Memory-mapped seven-segment display and debounced switch
//               peripheral. Optional blink support under macro SEG_BLINK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mmio_display_ctrl
    import mmio_display_pkg::*;
#(
    parameter int                NUM_DIGITS   = 4,
    parameter int                SW_W         = 8,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'hFF00,
    parameter int                DEBOUNCE_CYC = 16
`ifdef SEG_BLINK_EN
    ,
    parameter int                BLINK_DIV    = 2**22
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       bus_addr,
    input  logic [4*NUM_DIGITS-1:0] bus_wdata,
    input  logic                    bus_we,
    input  logic                    bus_re,
    output logic [4*NUM_DIGITS-1:0] bus_rdata,
    output logic                    bus_rvalid,
    input  logic [SW_W-1:0]         switches,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    sw_irq
);

    localparam int DW = 4 * NUM_DIGITS;
`ifdef SEG_BLINK_EN
    localparam int CTRL_W = 5;
`else
    localparam int CTRL_W = 4;
`endif
    localparam logic [CTRL_W-1:0] CTRL_RST = CTRL_W'(2);

    logic [DW-1:0]           display_q;
    logic [CTRL_W-1:0]       ctrl_q;
    logic                    sw_chg_q;
    logic                    irq_q;
    logic [DW-1:0]           rdata_q;
    logic                    rvalid_q;
    logic [7*NUM_DIGITS-1:0] seg_q;
    logic [7*NUM_DIGITS-1:0] seg_d;

    logic [ADDR_W-1:0] w_off;
    logic              w_hit;
    logic [1:0]        w_sel;
    logic              w_wr_disp;
    logic              w_wr_ctrl;
    logic              w_wr_status;
    logic [DW-1:0]     w_rd_val;
    logic [SW_W-1:0]   w_sw_stable;
    logic              w_sw_change;
    logic              w_sw_chg_d;
    logic              w_blink_hide;

    switch_debounce #(
        .W            (SW_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .sw_async_i (switches),
        .stable_o   (w_sw_stable),
        .change_o   (w_sw_change)
    );

    // Subtracting the base handles windows that are not 4-word aligned.
    assign w_off       = bus_addr - BASE_ADDR;
    assign w_hit       = (w_off[ADDR_W-1:2] == '0);
    assign w_sel       = w_off[1:0];
    assign w_wr_disp   = bus_we && w_hit && (w_sel == OFF_DISPLAY);
    assign w_wr_ctrl   = bus_we && w_hit && (w_sel == OFF_CTRL);
    assign w_wr_status = bus_we && w_hit && (w_sel == OFF_STATUS);

    // A fresh change outranks a simultaneous write-1-to-clear.
    assign w_sw_chg_d = w_sw_change || (sw_chg_q && !(w_wr_status && bus_wdata[0]));

    always_comb begin
        w_rd_val = '0;
        case (w_sel)
            OFF_DISPLAY: w_rd_val = display_q;
            OFF_CTRL:    w_rd_val = DW'(ctrl_q);
            OFF_SWITCH:  w_rd_val = DW'(w_sw_stable);
            default:     w_rd_val = DW'(sw_chg_q);
        endcase
    end

`ifdef SEG_BLINK_EN
    logic [31:0] blink_cnt_q;
    logic        blink_off_q;

    always_ff @(posedge clk) begin
        if (reset || w_wr_ctrl) begin
            blink_cnt_q <= '0;
            blink_off_q <= 1'b0;
        end else if (blink_cnt_q == 32'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_off_q <= !blink_off_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 32'd1;
        end
    end

    assign w_blink_hide = ctrl_q[CTRL_BLINK] && blink_off_q;
`else
    assign w_blink_hide = 1'b0;
`endif

    always_comb begin
        logic [DW-1:0] src;
        logic [3:0]    nib;
        logic          zero_above;
        seg_d      = '0;
        src        = ctrl_q[CTRL_SWMODE] ? DW'(w_sw_stable) : display_q;
        nib        = '0;
        zero_above = 1'b1;
        // Walk from the most significant digit so zero_above tracks leading zeros.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib        = src[4*i +: 4];
            zero_above = zero_above && (nib == 4'h0);
            if (!ctrl_q[CTRL_EN] || w_blink_hide) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else if (ctrl_q[CTRL_LZB] && zero_above && (i != 0)) begin
                seg_d[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_d[7*i +: 7] = hex2seg(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            display_q <= '0;
            ctrl_q    <= CTRL_RST;
            sw_chg_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            seg_q     <= {NUM_DIGITS{SEG_ZERO}};
        end else begin
            if (w_wr_disp) begin
                display_q <= bus_wdata;
            end
            if (w_wr_ctrl) begin
                ctrl_q <= CTRL_W'(bus_wdata);
            end
            sw_chg_q <= w_sw_chg_d;
            irq_q    <= sw_chg_q && ctrl_q[CTRL_IRQ_EN];
            rvalid_q <= bus_re && w_hit;
            rdata_q  <= (bus_re && w_hit) ? w_rd_val : '0;
            seg_q    <= seg_d;
        end
    end

    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;
    assign seg        = seg_q;
    assign sw_irq     = irq_q;

endmodule

`default_nettype wire
